// File: rtl/midi_rx_pkg.sv
// midi_pkg: shared types and constants for the MIDI receiver.
//   state_t    - receiver FSM states
//   MIDI_BAUD  - nominal MIDI line rate
//   MIDI_CLOCK - real-time "timing clock" status byte
//   MIDI_SENSE - real-time "active sensing" status byte
//   clog2()    - ceiling log2, usable in constant expressions
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int         MIDI_BAUD  = 31250;
  localparam logic [7:0] MIDI_CLOCK = 8'hF8;
  localparam logic [7:0] MIDI_SENSE = 8'hFE;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/midi_rx_if.sv
// midi_rx_if: byte-stream side of the MIDI receiver.
//   rd    - pop request from the reader (ignored while valid=0)
//   q     - FIFO head byte, meaningful while valid=1
//   valid - FIFO not empty
//   ferr  - one-cycle framing-error pulse
//   ovf   - one-cycle pulse when a good byte is dropped on a full FIFO
//   busy  - receiver is inside a frame (not IDLE)
// master = the reader (core / synth bridge), slave = midi_rx.
interface midi_rx_if;
  logic       rd;
  logic [7:0] q;
  logic       valid;
  logic       ferr;
  logic       ovf;
  logic       busy;

  modport master (output rd, input q, valid, ferr, ovf, busy);
  modport slave  (input rd, output q, valid, ferr, ovf, busy);
endinterface

// File: rtl/midi_rx_fifo.sv
// midi_fifo: first-word-fall-through byte FIFO.
//   clock, reset - system clock, synchronous active-high reset (empties FIFO)
//   push, din    - write request and data; a push while full is accepted only
//                  if a pop happens in the same cycle
//   full         - no free slot (before considering a same-cycle pop)
//   rd           - pop request, acts only while valid=1
//   valid, q     - not-empty flag and head byte (q reads 0 while empty)
// Pointers carry one extra MSB so full and empty can be told apart.
module midi_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] q
);

  localparam int AW = clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        pop;
  logic        do_push;

  assign valid   = (wr_ptr_reg != rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = rd && valid;
  // A same-cycle pop frees the head slot, which is exactly the slot the
  // write pointer aliases when full, so the push can land there.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Asynchronous read keeps the head visible the cycle valid rises; gating
  // with valid gives q=0 out of reset without clearing the array.
  assign q = valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

endmodule

// File: rtl/midi_rx.sv
// midi_rx: 8N1 idle-high serial MIDI receiver with a byte FIFO.
//   clock - system clock
//   reset - synchronous active-high reset (abandons any frame, empties FIFO)
//   rx    - raw asynchronous MIDI input pin
//   bus   - midi_rx_if.slave: rd / q / valid / ferr / ovf / busy
// Optional build macro MIDI_RX_REALTIME_FILTER_EN: when defined, completed
// 0xF8 and 0xFE bytes are dropped before the FIFO (no valid, no ovf).
module midi_rx
  import midi_pkg::*;
#(
  parameter int CLKHZ = 28000000,
  parameter int BAUD  = MIDI_BAUD,
  parameter int DEPTH = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     rx,
  midi_rx_if.slave bus
);

  localparam int BIT  = CLKHZ / BAUD;
  localparam int HALF = BIT / 2;
  localparam int CW   = clog2(BIT);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          rx_meta_reg, rxs_reg, rxs_d_reg;
  logic          ferr_reg, ferr_next;
  logic          ovf_reg, ovf_next;
  logic          push;
  logic          keep;
  logic          accept;
  logic          fifo_full;

  // Two-flop synchroniser plus one delay stage for falling-edge detection;
  // all reset to the idle (high) level so reset never looks like a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
      rxs_d_reg   <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
      rxs_d_reg   <= rxs_reg;
    end
  end

`ifdef MIDI_RX_REALTIME_FILTER_EN
  assign keep = (shift_reg != MIDI_CLOCK) && (shift_reg != MIDI_SENSE);
`else
  assign keep = 1'b1;
`endif

  assign accept = !fifo_full || (bus.rd && bus.valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      ferr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      ferr_reg  <= ferr_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    ferr_next  = 1'b0;
    ovf_next   = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rxs_d_reg && !rxs_reg) begin
          cnt_next   = HALF_M1;
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          if (!rxs_reg) begin
            cnt_next   = BIT_M1;
            idx_next   = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;  // start bit did not hold to mid-bit: glitch
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rxs_reg, shift_reg[7:1]};  // LSB arrives first
          cnt_next   = BIT_M1;
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          if (rxs_reg) begin
            if (keep) begin
              if (accept) push = 1'b1;
              else        ovf_next = 1'b1;
            end
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      BREAK: begin
        // Waiting for the line to return high keeps a held-low line from
        // reporting more than one framing error.
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  midi_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (shift_reg),
    .full  (fifo_full),
    .rd    (bus.rd),
    .valid (bus.valid),
    .q     (bus.q)
  );

  assign bus.ferr = ferr_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: self-checking bench for midi_rx. Runs with a reduced clock
// (BIT = 32 cycles) so the whole plan fits in a short run; every expected
// byte is queued on a scoreboard when sent and popped when read back.
module tb_midi_rx;
  import midi_pkg::*;

  localparam int CLKHZ = 1000000;
  localparam int BAUD  = MIDI_BAUD;
  localparam int DEPTH = 16;
  localparam int BIT   = CLKHZ / BAUD;
  localparam int HALF  = BIT / 2;
  // Cycles from driving the start edge on the pin to valid rising:
  // 2 sync + 1 edge detect + HALF to start sample + 9*BIT to stop sample
  // + 1 to the FIFO write (8515 at the default clock).
  localparam int LAT   = 3 + HALF + 9 * BIT;

`ifdef MIDI_RX_REALTIME_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       push;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic rx;
  int   cyc = 0;
  int   t0 = 0;
  int   ferr_cnt = 0;
  int   ovf_cnt = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [7:0] sb[$];

  midi_rx_if bus_if ();

  midi_rx #(.CLKHZ(CLKHZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus_if.ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (bus_if.ovf === 1'b1)  ovf_cnt  <= ovf_cnt + 1;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One frame on the pin: start, 8 data bits LSB first, stop, BIT cycles each.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(posedge clock);
    #1;
    rx = 1'b0;
    t0 = cyc;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1;
      rx = d[i];
      repeat (BIT) @(posedge clock);
    end
    #1;
    rx = stop_bit;
    repeat (BIT) @(posedge clock);
    $display("sent 0x%02h stop=%0b at cycle %0d", d, stop_bit, t0);
  endtask

  // Wait for valid, compare the head with the scoreboard, pop it with rd.
  task automatic pop_check(input string name);
    logic [7:0] exp;
    int w;
    w = 0;
    @(negedge clock);
    while (bus_if.valid !== 1'b1 && w < 12 * BIT) begin
      @(negedge clock);
      w++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    check({name, " valid"}, bus_if.valid, 1);
    check({name, " q"}, bus_if.q, exp);
    $display("pop %s q=0x%02h expected 0x%02h", name, bus_if.q, exp);
    if (bus_if.valid === 1'b1) begin
      bus_if.rd = 1'b1;
      @(negedge clock);
      bus_if.rd = 1'b0;
    end
  endtask

  task automatic drain_check(input string name);
    while (sb.size() > 0) pop_check(name);
    @(negedge clock);
    check({name, " empty"}, bus_if.valid, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int   rise;
    int   base_f;
    int   base_o;
    logic [7:0] exp;
    logic [7:0] tdata [8];

    tdata = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 8'hA5, 8'hFF, 8'h01};
    for (int i = 0; i < 8; i++) begin
      tbl[i].data = tdata[i];
      tbl[i].push = !(FILTER && (tdata[i] == 8'hF8 || tdata[i] == 8'hFE));
    end

    rx        = 1'b1;
    bus_if.rd = 1'b0;
    reset     = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("reset q", bus_if.q, 0);
    check("reset valid", bus_if.valid, 0);
    check("reset ferr", bus_if.ferr, 0);
    check("reset ovf", bus_if.ovf, 0);
    check("reset busy", bus_if.busy, 0);
    reset = 1'b0;

    // Idle line: nothing happens.
    repeat (2000) @(negedge clock);
    check("idle valid", bus_if.valid, 0);
    check("idle busy", bus_if.busy, 0);
    check("idle ferr count", ferr_cnt, 0);
    check("idle ovf count", ovf_cnt, 0);

    // rd on an empty FIFO is ignored.
    bus_if.rd = 1'b1;
    repeat (2) @(negedge clock);
    bus_if.rd = 1'b0;
    check("rd empty valid", bus_if.valid, 0);

    // 0x90 with latency window.
    rise = -1;
    fork
      send_byte(8'h90, 1'b1);
      begin
        for (int i = 0; i < LAT + 4 * BIT; i++) begin
          @(negedge clock);
          if (bus_if.valid === 1'b1) begin
            rise = cyc - t0;
            break;
          end
        end
        check("0x90 q at rise", bus_if.q, 8'h90);
      end
    join
    n_vec++;
    if (rise < LAT || rise > LAT + 3) begin
      n_miss++;
      $display("FAIL 0x90 latency: got %0d cycles, expected %0d..%0d", rise, LAT, LAT + 3);
    end
    sb.push_back(8'h90);
    pop_check("0x90");
    check("0x90 valid after rd", bus_if.valid, 0);

    // Short low glitch: rejected at the start sample.
    base_f = ferr_cnt;
    @(posedge clock);
    #1;
    rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    rx = 1'b1;
    @(negedge clock);
    check("glitch busy during", bus_if.busy, 1);
    repeat (2 * BIT) @(negedge clock);
    check("glitch busy after", bus_if.busy, 0);
    check("glitch valid", bus_if.valid, 0);
    check("glitch ferr", ferr_cnt - base_f, 0);
    send_byte(8'h3C, 1'b1);
    sb.push_back(8'h3C);
    pop_check("0x3C after glitch");

    // Framing error then held-low break: exactly one ferr.
    base_f = ferr_cnt;
    send_byte(8'h45, 1'b0);
    repeat (20 * BIT) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    check("break ferr count", ferr_cnt - base_f, 1);
    check("break valid", bus_if.valid, 0);
    check("break busy", bus_if.busy, 0);
    send_byte(8'h7F, 1'b1);
    sb.push_back(8'h7F);
    pop_check("0x7F after break");

    // Overflow: 17 bytes into a 16-deep FIFO, no reads.
    base_o = ovf_cnt;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1);
      if (i < DEPTH) sb.push_back(8'(i));
    end
    repeat (BIT) @(negedge clock);
    check("overflow ovf count", ovf_cnt - base_o, 1);
    drain_check("overflow readback");

    // Same, but pop in the cycle of the 17th push: nothing is lost.
    base_o = ovf_cnt;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1);
      sb.push_back(8'(i));
    end
    sb.push_back(8'h10);
    fork
      send_byte(8'h10, 1'b1);
      begin
        @(posedge clock);
        #2;
        while (cyc < t0 + LAT - 1) @(negedge clock);
        exp = sb.pop_front();
        check("full pop+push head", bus_if.q, exp);
        bus_if.rd = 1'b1;
        @(negedge clock);
        bus_if.rd = 1'b0;
      end
    join
    repeat (BIT) @(negedge clock);
    check("pop+push ovf count", ovf_cnt - base_o, 0);
    drain_check("pop+push readback");

    // Table of frames, including the real-time bytes.
    base_o = ovf_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].data, 1'b1);
      if (tbl[i].push) sb.push_back(tbl[i].data);
    end
    repeat (BIT) @(negedge clock);
    check("table ovf count", ovf_cnt - base_o, 0);
    drain_check("table");

    // Reset empties the FIFO and abandons a frame in progress.
    send_byte(8'h11, 1'b1);
    @(negedge clock);
    check("pre-reset valid", bus_if.valid, 1);
    base_f = ferr_cnt;
    base_o = ovf_cnt;
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (4 * BIT) @(negedge clock);
        check("mid-frame busy", bus_if.busy, 1);
        reset = 1'b1;
      end
    join
    @(negedge clock);
    check("mid-reset valid", bus_if.valid, 0);
    check("mid-reset busy", bus_if.busy, 0);
    check("mid-reset q", bus_if.q, 0);
    reset = 1'b0;
    sb.delete();
    repeat (2 * BIT) @(negedge clock);
    check("post-reset ferr", ferr_cnt - base_f, 0);
    check("post-reset ovf", ovf_cnt - base_o, 0);
    check("post-reset valid", bus_if.valid, 0);
    send_byte(8'h22, 1'b1);
    sb.push_back(8'h22);
    pop_check("0x22 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
